// File: rtl/sbox_server.sv
// rtl/sbox_server.sv - shared S-box datapath: port A byte-serial, port B SubWord in idle cycles
module sbox_server #(
    parameter int B_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_active_i,
    input  logic [7:0]           a_data_i,
    input  logic                 a_decrypt_i,
    output logic [7:0]           a_data_o,
    input  logic                 b_start_i,
    input  logic [8*B_BYTES-1:0] b_word_i,
    output logic                 b_ready_o,
    output logic [8*B_BYTES-1:0] b_word_o
);

    localparam int W  = 8 * B_BYTES;
    localparam int CW = $clog2(B_BYTES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [W-1:0]    b_word_q;
    logic [W-1:0]    out_word;
    logic [W-1:0]    out_next;
    logic [CW-1:0]   issue_cnt;
    logic [CW-1:0]   cap_cnt;
    logic            issue_v;
    logic [7:0]      result_q;
    logic [7:0]      issue_byte;
    logic [7:0]      sbox_in;
    logic            sbox_dir;
    logic            issue_now;
    logic            last_cap;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0 for free
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    // One inverter shared by both directions; the affine steps sit on either side
    function automatic logic [7:0] sbox(input logic [7:0] x, input logic dec);
        logic [7:0] t;
        logic [7:0] u;
        t = dec ? inv_affine(x) : x;
        u = gf_inv(t);
        return dec ? u : fwd_affine(u);
    endfunction

    always_comb begin
        issue_now  = (state == RUN) && !a_active_i && (issue_cnt < CW'(B_BYTES));
        issue_byte = 8'h00;
        out_next   = out_word;
        for (int k = 0; k < B_BYTES; k++) begin
            if (issue_cnt == CW'(k)) issue_byte = b_word_q[8*(B_BYTES-1-k) +: 8];
            if (cap_cnt == CW'(k))   out_next[8*(B_BYTES-1-k) +: 8] = result_q;
        end
        sbox_in  = issue_now ? issue_byte : a_data_i;
        sbox_dir = issue_now ? 1'b0 : a_decrypt_i;
        last_cap = issue_v && (cap_cnt == CW'(B_BYTES - 1));
    end

    assign a_data_o = result_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            b_word_q  <= '0;
            out_word  <= '0;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            issue_v   <= 1'b0;
            result_q  <= 8'h00;
            b_ready_o <= 1'b0;
            b_word_o  <= '0;
        end else begin
            result_q  <= sbox(sbox_in, sbox_dir);
            b_ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    issue_v <= 1'b0;
                    if (b_start_i) begin
                        b_word_q  <= b_word_i;
                        issue_cnt <= '0;
                        cap_cnt   <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // A byte issued last cycle is already in result_q, so capture never stalls
                    issue_v <= issue_now;
                    if (issue_now) issue_cnt <= issue_cnt + CW'(1);
                    if (issue_v) begin
                        out_word <= out_next;
                        cap_cnt  <= cap_cnt + CW'(1);
                    end
                    if (last_cap) begin
                        b_word_o  <= out_next;
                        b_ready_o <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
